// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode stage with operand forwarding, hazard stall and one-entry output register
//
// Purpose:
//   Extracts rs1/rs2 from the incoming instruction and resolves each operand
//   from the forwarding sources or the register file. Stalls upstream while the
//   winning producer's data is still pending. The resolved instruction is
//   captured into a single output register with a valid/ready handshake.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   in_valid/in_ready          upstream handshake (in_ready is combinational)
//   in_inst/in_pc/in_counter   incoming instruction fields
//   fwd_en/fwd_pending         per-source write enable / data-not-yet-ready
//   fwd_addr/fwd_data          per-source destination register / write data
//   regs_value                 flattened architectural register file (x0..x31)
//   flush                      drop held and incoming instructions
//   out_valid/out_ready        downstream handshake
//   out_rs1/out_rs2            captured source indices
//   out_rs1_val/out_rs2_val    captured resolved operands
//   out_inst/out_pc/out_counter captured instruction fields
//   stall_count                saturating count of hazard-stall cycles

module decode_stage #(
  parameter int XLEN    = 64,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_inst,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [XLEN-1:0]         in_counter,

  input  logic [NUM_FWD-1:0]      fwd_en,
  input  logic [NUM_FWD-1:0]      fwd_pending,
  input  logic [NUM_FWD*5-1:0]    fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,

  input  logic [32*XLEN-1:0]      regs_value,
  input  logic                    flush,

  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4:0]              out_rs1,
  output logic [4:0]              out_rs2,
  output logic [XLEN-1:0]         out_rs1_val,
  output logic [XLEN-1:0]         out_rs2_val,
  output logic [31:0]             out_inst,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_counter,

  output logic [CNT_W-1:0]        stall_count
);

  // --------------------------------------------------------------------------
  // Source register extraction and operand resolution
  // --------------------------------------------------------------------------
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            rs1_pend;
  logic            rs2_pend;

  assign rs1 = in_inst[19:15];
  assign rs2 = in_inst[24:20];

  // Sources are scanned from the oldest (highest index) down to the youngest
  // so that the last match written, i.e. the lowest index, wins. Only the
  // winning source's pending flag is kept, so an older pending producer that
  // is shadowed by a younger one never causes a stall.
  always_comb begin
    rs1_val  = regs_value[32'(rs1)*XLEN +: XLEN];
    rs1_pend = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_en[i] && (fwd_addr[i*5 +: 5] != 5'd0) && (fwd_addr[i*5 +: 5] == rs1)) begin
        rs1_val  = fwd_data[i*XLEN +: XLEN];
        rs1_pend = fwd_pending[i];
      end
    end
    // x0 is hardwired to zero whatever the register file image says.
    if (rs1 == 5'd0) begin
      rs1_val  = '0;
      rs1_pend = 1'b0;
    end
  end

  always_comb begin
    rs2_val  = regs_value[32'(rs2)*XLEN +: XLEN];
    rs2_pend = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_en[i] && (fwd_addr[i*5 +: 5] != 5'd0) && (fwd_addr[i*5 +: 5] == rs2)) begin
        rs2_val  = fwd_data[i*XLEN +: XLEN];
        rs2_pend = fwd_pending[i];
      end
    end
    if (rs2 == 5'd0) begin
      rs2_val  = '0;
      rs2_pend = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Handshake control
  // --------------------------------------------------------------------------
  logic out_valid_q, out_valid_d;
  logic hazard;
  logic slot_free;
  logic capture;

  assign hazard    = in_valid && (rs1_pend || rs2_pend);
  assign slot_free = !out_valid_q || out_ready;
  // Gating with reset keeps in_ready low for the whole time reset is held,
  // even though the emptied output slot would otherwise look free.
  assign in_ready  = reset && slot_free && !hazard && !flush;
  assign capture   = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Output register next-state
  // --------------------------------------------------------------------------
  logic [4:0]       rs1_q, rs1_d;
  logic [4:0]       rs2_q, rs2_d;
  logic [XLEN-1:0]  rs1_val_q, rs1_val_d;
  logic [XLEN-1:0]  rs2_val_q, rs2_val_d;
  logic [31:0]      inst_q, inst_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  counter_q, counter_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // Data fields only ever load on capture; bubbles, holds and flushes keep
  // them as they are, so out_ready can only influence out_valid.
  always_comb begin
    out_valid_d = out_valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rs1_val_d   = rs1_val_q;
    rs2_val_d   = rs2_val_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    counter_d   = counter_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      rs1_d       = rs1;
      rs2_d       = rs2;
      rs1_val_d   = rs1_val;
      rs2_val_d   = rs2_val;
      inst_d      = in_inst;
      pc_d        = in_pc;
      counter_d   = in_counter;
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end
  end

  // A stall cycle is one where the slot could have taken the instruction but
  // the operand was not ready. Cycles blocked downstream are not counted.
  always_comb begin
    stall_d = stall_q;
    if (hazard && slot_free && !flush && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      inst_q      <= '0;
      pc_q        <= '0;
      counter_q   <= '0;
      stall_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      counter_q   <= counter_d;
      stall_q     <= stall_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_rs1     = rs1_q;
  assign out_rs2     = rs2_q;
  assign out_rs1_val = rs1_val_q;
  assign out_rs2_val = rs2_val_q;
  assign out_inst    = inst_q;
  assign out_pc      = pc_q;
  assign out_counter = counter_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage

module tb_decode_stage;

  localparam int XLEN = 64;
  localparam int NF   = 3;
  localparam int CW   = 4;
  localparam int SMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_inst;
  logic [XLEN-1:0]      in_pc;
  logic [XLEN-1:0]      in_counter;
  logic [NF-1:0]        fwd_en;
  logic [NF-1:0]        fwd_pending;
  logic [NF*5-1:0]      fwd_addr;
  logic [NF*XLEN-1:0]   fwd_data;
  logic [32*XLEN-1:0]   regs_value;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [4:0]           out_rs1;
  logic [4:0]           out_rs2;
  logic [XLEN-1:0]      out_rs1_val;
  logic [XLEN-1:0]      out_rs2_val;
  logic [31:0]          out_inst;
  logic [XLEN-1:0]      out_pc;
  logic [XLEN-1:0]      out_counter;
  logic [CW-1:0]        stall_count;

  logic [4:0]      fa   [NF];
  logic [XLEN-1:0] fd   [NF];
  logic [XLEN-1:0] regs [32];

  genvar g;
  for (g = 0; g < NF; g++) begin : g_fwd
    assign fwd_addr[g*5 +: 5]       = fa[g];
    assign fwd_data[g*XLEN +: XLEN] = fd[g];
  end
  for (g = 0; g < 32; g++) begin : g_regs
    assign regs_value[g*XLEN +: XLEN] = regs[g];
  end

  decode_stage #(.XLEN(XLEN), .NUM_FWD(NF), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_counter(in_counter),
    .fwd_en(fwd_en), .fwd_pending(fwd_pending), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .regs_value(regs_value), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_inst(out_inst), .out_pc(out_pc), .out_counter(out_counter),
    .stall_count(stall_count)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: contents of the output slot and the stall counter.
  bit              m_valid;
  logic [4:0]      m_rs1, m_rs2;
  logic [XLEN-1:0] m_v1, m_v2, m_pc, m_cnt;
  logic [31:0]     m_inst;
  int              m_stall;

  function automatic logic [31:0] mk_inst(input logic [4:0] r1, input logic [4:0] r2);
    return {7'b0, r2, r1, 3'b000, 5'd1, 7'h33};
  endfunction

  // Youngest enabled producer naming the register supplies it; x0 reads zero.
  function automatic logic [XLEN-1:0] ref_operand(input logic [4:0] rs, output bit pend);
    pend = 1'b0;
    if (rs == 5'd0) return '0;
    for (int i = 0; i < NF; i++) begin
      if (fwd_en[i] && fa[i] == rs) begin
        pend = fwd_pending[i];
        return fd[i];
      end
    end
    return regs[rs];
  endfunction

  function automatic bit exp_ready();
    bit p1, p2;
    logic [XLEN-1:0] v1, v2;
    v1 = ref_operand(in_inst[19:15], p1);
    v2 = ref_operand(in_inst[24:20], p2);
    return reset && (!m_valid || out_ready) && !(in_valid && (p1 || p2)) && !flush;
  endfunction

  function automatic logic [298:0] exp_vec();
    return {m_valid, m_rs1, m_rs2, m_v1, m_v2, m_inst, m_pc, m_cnt};
  endfunction

  function automatic logic [298:0] act_vec();
    return {out_valid, out_rs1, out_rs2, out_rs1_val, out_rs2_val, out_inst, out_pc, out_counter};
  endfunction

  task automatic model_clear();
    m_valid = 1'b0; m_rs1 = '0; m_rs2 = '0; m_v1 = '0; m_v2 = '0;
    m_inst = '0; m_pc = '0; m_cnt = '0; m_stall = 0;
  endtask

  // Advance one clock and update the model from the inputs present before the edge.
  task automatic tick();
    bit p1, p2, hz, sf, rdy;
    logic [XLEN-1:0] v1, v2;
    v1  = ref_operand(in_inst[19:15], p1);
    v2  = ref_operand(in_inst[24:20], p2);
    hz  = in_valid && (p1 || p2);
    sf  = !m_valid || out_ready;
    rdy = reset && sf && !hz && !flush;
    @(posedge clk);
    if (!reset) begin
      model_clear();
    end else begin
      if (flush) m_valid = 1'b0;
      else if (in_valid && rdy) begin
        m_valid = 1'b1; m_rs1 = in_inst[19:15]; m_rs2 = in_inst[24:20];
        m_v1 = v1; m_v2 = v2; m_inst = in_inst; m_pc = in_pc; m_cnt = in_counter;
      end else if (sf) m_valid = 1'b0;
      if (hz && sf && !flush && m_stall < SMAX) m_stall++;
    end
    #1;
  endtask

  task automatic set_idle();
    in_valid = 1'b0; in_inst = '0; in_pc = '0; in_counter = '0;
    fwd_en = '0; fwd_pending = '0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < NF; i++) begin fa[i] = '0; fd[i] = '0; end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
    #1;
    reset = 1'b0;
    in_valid = 1'b1;
    in_inst = mk_inst(5'd1, 5'd2);
    #2;
    tests_run++;
    if (act_vec() !== '0 || stall_count !== '0) begin
      tests_failed++;
      $display("FAIL reset_state got %h/%h want 0/0", act_vec(), stall_count);
    end
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_ready got %b want 0", in_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
    in_pc = 64'h1000; in_counter = 64'd1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_first_ready got %b want 1", in_ready);
    end
    tick();
    tests_run++;
    if (act_vec() !== exp_vec() || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_first_capture got %h want %h", act_vec(), exp_vec());
    end
    set_idle();
    tick();
  endtask

  task automatic test_basic();
    regs[1] = 64'd5; regs[2] = 64'd7;
    in_inst = 32'h00208033; in_pc = {$urandom, $urandom}; in_counter = {$urandom, $urandom};
    fwd_en = '0; out_ready = 1'b1; in_valid = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== exp_ready()) begin
      tests_failed++;
      $display("FAIL basic_in_ready got %b want %b", in_ready, exp_ready());
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_rs1_val !== 64'd5 || out_rs2_val !== 64'd7 ||
        out_rs1 !== 5'd1 || out_rs2 !== 5'd2) begin
      tests_failed++;
      $display("FAIL basic_add got v=%b %0d:%h %0d:%h want v=1 1:5 2:7",
               out_valid, out_rs1, out_rs1_val, out_rs2, out_rs2_val);
    end
    tests_run++;
    if (act_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL basic_vec got %h want %h", act_vec(), exp_vec());
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (act_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL basic_bubble got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_priority();
    in_inst = mk_inst(5'd3, 5'd0); in_valid = 1'b1; out_ready = 1'b1;
    fwd_en = 3'b101; fwd_pending = '0;
    fa[0] = 5'd3; fd[0] = 64'hAA;
    fa[1] = 5'd3; fd[1] = 64'h11;
    fa[2] = 5'd3; fd[2] = 64'hBB;
    tick();
    tests_run++;
    if (out_rs1_val !== 64'hAA || act_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL prio_youngest got %h want aa (vec %h want %h)", out_rs1_val, act_vec(), exp_vec());
    end
    regs[0] = 64'hDEAD;
    in_inst = mk_inst(5'd0, 5'd0);
    fwd_en = 3'b001; fa[0] = 5'd0; fd[0] = 64'hCC;
    tick();
    tests_run++;
    if (out_rs1_val !== 64'h0 || act_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL prio_x0 got %h want 0 (vec %h want %h)", out_rs1_val, act_vec(), exp_vec());
    end
    regs[0] = '0;
    set_idle();
  endtask

  task automatic test_hazard();
    do_reset();
    set_idle();
    in_inst = mk_inst(5'd0, 5'd4); in_valid = 1'b1;
    fwd_en = 3'b110; fa[1] = 5'd4; fa[2] = 5'd4; fd[2] = 64'h99;
    fwd_pending = 3'b010;
    for (int c = 0; c < 2; c++) begin
      fd[1] = {$urandom, $urandom};
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL hazard_in_ready c%0d got %b want 0", c, in_ready);
      end
      tick();
      tests_run++;
      if (act_vec() !== exp_vec() || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL hazard_bubble c%0d got %h want %h", c, act_vec(), exp_vec());
      end
    end
    // fwd2 stays pending but is shadowed by the younger fwd1.
    fwd_pending = 3'b100; fd[1] = 64'h55;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL hazard_release got %b want 1", in_ready);
    end
    tick();
    tests_run++;
    if (out_rs2_val !== 64'h55 || stall_count !== 4'd2 || act_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL hazard_capture got %h stall %0d want 55 stall 2", out_rs2_val, stall_count);
    end
    set_idle();
  endtask

  task automatic test_hold();
    logic [298:0] snap;
    int           st;
    in_inst = mk_inst(5'd5, 5'd6); in_valid = 1'b1; out_ready = 1'b1;
    in_pc = 64'h2000; in_counter = 64'd7;
    fwd_en = 3'b001; fa[0] = 5'd5; fd[0] = 64'h1234;
    tick();
    snap = act_vec();
    st = m_stall;
    in_inst = mk_inst(5'd6, 5'd5); in_pc = 64'h2004; in_counter = 64'd8;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      fd[0] = {$urandom, $urandom};
      fwd_pending = (c == 1) ? 3'b001 : 3'b000;
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_in_ready c%0d got %b want 0", c, in_ready);
      end
      tick();
      tests_run++;
      if (act_vec() !== exp_vec() || act_vec() !== snap || stall_count !== CW'(st)) begin
        tests_failed++;
        $display("FAIL hold_stable c%0d got %h stall %0d want %h stall %0d", c, act_vec(), stall_count, exp_vec(), st);
      end
    end
    fwd_pending = '0; out_ready = 1'b1;
    tick();
    tests_run++;
    if (act_vec() !== exp_vec() || out_inst !== mk_inst(5'd6, 5'd5)) begin
      tests_failed++;
      $display("FAIL hold_next got %h want %h", act_vec(), exp_vec());
    end
    set_idle();
  endtask

  task automatic test_flush();
    int st;
    in_inst = mk_inst(5'd7, 5'd8); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    st = m_stall;
    fwd_en = 3'b001; fa[0] = 5'd7; fwd_pending = 3'b001; flush = 1'b1; out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_in_ready got %b want 0", in_ready);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || stall_count !== CW'(st) || act_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL flush_drop got v=%b stall %0d want v=0 stall %0d", out_valid, stall_count, st);
    end
    set_idle();
  endtask

  task automatic test_saturate();
    do_reset();
    set_idle();
    in_inst = mk_inst(5'd9, 5'd0); in_valid = 1'b1;
    fwd_en = 3'b010; fa[1] = 5'd9; fwd_pending = 3'b010;
    for (int c = 0; c < 20; c++) begin
      tick();
      tests_run++;
      if (stall_count !== CW'(m_stall)) begin
        tests_failed++;
        $display("FAIL sat_count c%0d got %0d want %0d", c, stall_count, m_stall);
      end
    end
    tests_run++;
    if (stall_count !== 4'd15) begin
      tests_failed++;
      $display("FAIL sat_final got %0d want 15", stall_count);
    end
    fwd_pending = '0; out_ready = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (act_vec() !== '0 || stall_count !== '0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_async_reset got %h stall %0d rdy %b want 0", act_vec(), stall_count, in_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
    set_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_inst    = $urandom;
      in_inst[19:15] = 5'($urandom_range(0, 7));
      in_inst[24:20] = 5'($urandom_range(0, 7));
      in_pc      = {$urandom, $urandom};
      in_counter = {$urandom, $urandom};
      fwd_en     = 3'($urandom);
      for (int i = 0; i < NF; i++) begin
        fa[i] = 5'($urandom_range(0, 7));
        fd[i] = {$urandom, $urandom};
        fwd_pending[i] = ($urandom_range(0, 3) == 0);
      end
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, 31)] = {$urandom, $urandom};
      #1;
      tests_run++;
      if (in_ready !== exp_ready()) begin
        tests_failed++;
        $display("FAIL rand_in_ready c%0d got %b want %b", c, in_ready, exp_ready());
      end
      tick();
      tests_run++;
      if (act_vec() !== exp_vec() || stall_count !== CW'(m_stall)) begin
        tests_failed++;
        $display("FAIL rand_out c%0d got %h stall %0d want %h stall %0d", c, act_vec(), stall_count, exp_vec(), m_stall);
      end
      if (c == 200) do_reset();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_hazard();
    test_hold();
    test_flush();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 64, register data width.
REQ-002 Parameter NUM_FWD, default 3, number of forwarding sources; legal range 1..8.
REQ-003 Parameter CNT_W, default 32, stall counter width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 in_valid  in  1  upstream instruction valid.
REQ-007 in_ready  out  1  stage accepts the upstream instruction this cycle.
REQ-008 in_inst  in  32  instruction word.
REQ-009 in_pc  in  XLEN  instruction PC.
REQ-010 in_counter  in  XLEN  instruction sequence counter.
REQ-011 fwd_en  in  NUM_FWD  per-source write enable.
REQ-012 fwd_pending  in  NUM_FWD  per-source write data not yet available (e.g. load in flight).
REQ-013 fwd_addr  in  NUM_FWD*5  per-source destination register.
REQ-014 fwd_data  in  NUM_FWD*XLEN  per-source write data.
REQ-015 regs_value  in  32*XLEN  architectural register file contents.
REQ-016 flush  in  1  discard held and incoming instructions.
REQ-017 out_valid, out_ready  out/in  1 each  downstream handshake.
REQ-018 out_rs1, out_rs2  out  5 each  captured source register indices.
REQ-019 out_rs1_val, out_rs2_val  out  XLEN each  resolved operand values.
REQ-020 out_inst, out_pc, out_counter  out  32/XLEN/XLEN  captured instruction fields.
REQ-021 stall_count  out  CNT_W  saturating count of hazard-stall cycles.

Function
REQ-022 rs1 = in_inst[19:15], rs2 = in_inst[24:20]; both always treated as read.
REQ-023 Source i matches rsN when fwd_en[i]=1, fwd_addr[i]!=0 and fwd_addr[i]==rsN.
REQ-024 Lowest matching index has priority (index 0 = youngest producer); higher-index matches are ignored.
REQ-025 Resolved value = fwd_data of winning source; with no match, regs_value[rsN]; rsN==0 always yields 0 regardless of regs_value.
REQ-026 hazard = in_valid and, for rs1 or rs2, the winning source has fwd_pending=1; a pending non-winning source causes no hazard.
REQ-027 slot_free = !out_valid || out_ready.
REQ-028 in_ready = slot_free && !hazard && !flush; combinational.
REQ-029 Capture: in_valid && in_ready -> next cycle out_valid=1, all out_* = registered in_*/resolved values (latency 1 cycle).
REQ-030 Bubble: slot_free && !(in_valid && in_ready) -> next cycle out_valid=0; out data fields hold their previous values.
REQ-031 Hold: out_valid && !out_ready && !flush -> all out_* unchanged (stable while stalled downstream).
REQ-032 flush=1 -> next cycle out_valid=0, no capture, overrides all other cases incl. simultaneous in_valid and hazard.
REQ-033 Forwarding is sampled only at capture; later fwd_* changes never alter held outputs.
REQ-034 stall_count increments by 1 on each cycle with hazard && slot_free && !flush; saturates at 2^CNT_W-1, no wrap.
REQ-035 No combinational path from out_ready to out_* data; out_ready -> in_ready path is permitted.

Reset
REQ-036 reset=0 asynchronously forces out_valid=0, all out_* data=0, stall_count=0.
REQ-037 in_ready is 0 during reset; first capture possible on the first rising edge after reset deasserts.
REQ-038 Reset asserted mid-stall or mid-hold discards the held instruction; no partial state survives.

Verification
REQ-039 in_inst=0x00208033 (add x0,x1,x2), fwd_en=0, regs x1=5, x2=7, out_ready=1 -> next cycle out_valid=1, out_rs1_val=5, out_rs2_val=7, out_rs1=1, out_rs2=2.
REQ-040 rs1=x3, fwd0 (addr 3, data 0xAA) and fwd2 (addr 3, data 0xBB) both enabled -> out_rs1_val=0xAA; fwd0 addr=0, data 0xCC, rs1=x0 -> out_rs1_val=0.
REQ-041 rs2=x4 winner fwd1 pending for 2 cycles, then pending=0, data 0x55 -> in_ready=0 two cycles, two bubbles, stall_count=2, then capture with out_rs2_val=0x55.
REQ-042 out_valid=1, out_ready=0 for 3 cycles while in_valid=1 and fwd_data toggles -> out_* stable, in_ready=0, stall_count unchanged; out_ready=1 -> next instruction captured.
REQ-043 flush=1 with in_valid=1 and hazard=1 -> in_ready=0, next cycle out_valid=0, stall_count unchanged.
REQ-044 CNT_W=4, 20 hazard cycles -> stall_count=15; reset pulsed low mid-hold -> out_valid=0 immediately, stall_count=0.
